// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core memory stage.
package mips_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;

  localparam int WORD_BYTES = 4;

  function automatic logic is_misaligned(input logic [31:0] a);
    return (a & 32'(WORD_BYTES - 1)) != 32'd0;
  endfunction

endpackage

// File: rtl/dmem_stall_ctrl_if.sv
// Datapath <-> data-memory handshake: request strobes, address/data and stall/fault.
interface dmem_stall_ctrl_if;

  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        fault;

  modport master (
    output memread, memwrite, addr, writedata,
    input  readdata, stall, fault
  );

  modport slave (
    input  memread, memwrite, addr, writedata,
    output readdata, stall, fault
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; registered read data, read-before-write on one edge.
module dmem_array #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);

  logic [31:0] mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rd <= '0;
    else if (re) rd <= mem[idx];
  end

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Data-memory stage: services loads/stores with a fixed latency and stalls the PC meanwhile.
//   state | meaning
//   IDLE  | waiting for memread/memwrite; misaligned requests only set fault
//   BUSY  | access in flight, counter running down; array touched when it hits 0
//   DONE  | one-cycle retire slot, stall low, requests ignored
module dmem_stall_ctrl
  import mips_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  dmem_stall_ctrl_if.slave    bus
);

  localparam int OFS = $clog2(WORD_BYTES);
  localparam int AW  = $clog2(DEPTH);

  dmem_state_t   state_q, state_d;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          rd_op_q, wr_op_q;
  logic          fault_q;

  logic          req, mis;
  logic          capture, fault_set, stall;
  logic          mem_re, mem_we;
  logic [31:0]   rd;
  logic          unused_addr;

  assign req = bus.memread | bus.memwrite;
  assign mis = is_misaligned(bus.addr);

  // High address bits are dropped so the array aliases modulo DEPTH words.
  assign unused_addr = ^bus.addr[31:AW+OFS];

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    fault_set = 1'b0;
    stall     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && !mis) begin
          capture = 1'b1;
          stall   = 1'b1;
          state_d = BUSY;
        end else if (req && mis) begin
          fault_set = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          mem_re  = rd_op_q;
          mem_we  = wr_op_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_op_q <= 1'b0;
      wr_op_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cnt_q   <= 4'(LATENCY - 1);
        idx_q   <= bus.addr[AW+OFS-1:OFS];
        wdata_q <= bus.writedata;
        rd_op_q <= bus.memread;
        wr_op_q <= bus.memwrite;
      end else if (state_q == BUSY && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (fault_set) fault_q <= 1'b1;
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .reset (reset),
    .re    (mem_re),
    .we    (mem_we),
    .idx   (idx_q),
    .wd    (wdata_q),
    .rd    (rd)
  );

  assign bus.readdata = rd;
  assign bus.stall    = stall;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Scoreboard bench for dmem_stall_ctrl: directed accesses push expectations, a monitor checks completions.
module tb_dmem_stall_ctrl;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  dmem_stall_ctrl_if ifc();

  dmem_stall_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Completion = first non-stalled sample after a stalled run (the DONE cycle).
  initial begin : monitor
    int   run_len;
    logic prev;
    exp_t e;
    run_len = 0;
    prev    = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run_len = 0;
        prev    = 1'b0;
      end else begin
        if (ifc.stall) begin
          run_len++;
        end else if (prev) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_completion: got completion with rd=0x%08h, want none", ifc.readdata);
          end else begin
            e = exp_q.pop_front();
            check({e.name, "_rd"},        ifc.readdata,      e.rd);
            check({e.name, "_fault"},     {31'b0, ifc.fault}, {31'b0, e.fault});
            check({e.name, "_stall_len"}, 32'(run_len),      32'(LATENCY + 1));
          end
          run_len = 0;
        end
        prev = ifc.stall;
      end
    end
  end

  // Called at posedge+1 in IDLE; returns at posedge+1 after DONE with inputs still driven.
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_fault);
    exp_t e;
    int   k;
    e.name  = name;
    e.rd    = exp_rd;
    e.fault = exp_fault;
    exp_q.push_back(e);
    ifc.memread   = rd;
    ifc.memwrite  = wr;
    ifc.addr      = a;
    ifc.writedata = wd;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (!ifc.stall) break;
      k++;
    end
    if (k == 20) begin
      n_checks++;
      $display("FAIL %s_timeout: got stall high for 20 cycles, want low", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ifc.memread  = 1'b0;
    ifc.memwrite = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_stall", {31'b0, ifc.stall}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    ifc.memread   = 1'b0;
    ifc.memwrite  = 1'b0;
    ifc.addr      = '0;
    ifc.writedata = '0;
    reset         = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    @(negedge clk);
    check("reset_rd",    ifc.readdata,        32'd0);
    check("reset_stall", {31'b0, ifc.stall},  32'd0);
    check("reset_fault", {31'b0, ifc.fault},  32'd0);
    @(posedge clk);
    #1;
    idle(5);

    access("wr_10",   1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
    access("rd_10",   1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    access("wr_104",  1'b0, 1'b1, 32'h104, 32'h12345678, 32'hDEADBEEF, 1'b0);
    access("rd_004",  1'b1, 1'b0, 32'h004, 32'h0,        32'h12345678, 1'b0);

    // Misaligned load aliases word 0x10 but must not touch it.
    ifc.memread  = 1'b1;
    ifc.memwrite = 1'b0;
    ifc.addr     = 32'h13;
    @(negedge clk);
    check("mis_stall",        {31'b0, ifc.stall}, 32'd0);
    check("mis_fault_before", {31'b0, ifc.fault}, 32'd0);
    @(posedge clk);
    #1 ifc.memread = 1'b0;
    @(negedge clk);
    check("mis_fault_after", {31'b0, ifc.fault}, 32'd1);
    check("mis_rd_hold",     ifc.readdata,       32'h12345678);
    @(posedge clk);
    #1;

    access("rd_10_after_mis", 1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b1);
    access("wr_20_init",      1'b0, 1'b1, 32'h20, 32'h11111111, 32'hDEADBEEF, 1'b1);

    // Reset in the second BUSY cycle of a write: the write must be abandoned.
    ifc.memread   = 1'b0;
    ifc.memwrite  = 1'b1;
    ifc.addr      = 32'h20;
    ifc.writedata = 32'hA5A5A5A5;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("busy_before_reset", {31'b0, ifc.stall}, 32'd1);
    reset        = 1'b0;
    ifc.memwrite = 1'b0;
    #1;
    check("reset_stall_drop", {31'b0, ifc.stall}, 32'd0);
    check("reset_fault_clr",  {31'b0, ifc.fault}, 32'd0);
    check("reset_rd_clr",     ifc.readdata,       32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(1);

    access("rd_20_after_reset", 1'b1, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
    access("wr_08",             1'b0, 1'b1, 32'h08, 32'h1, 32'h11111111, 1'b0);
    access("rw_08",             1'b1, 1'b1, 32'h08, 32'h2, 32'h00000001, 1'b0);
    access("rd_08",             1'b1, 1'b0, 32'h08, 32'h0, 32'h00000002, 1'b0);
    idle(3);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
